// File: rtl/card_match_ctrl_pkg.sv
// Shared types, FSM states and default sizing for the card-matching game controller.
package card_pkg;
   localparam int NUM_CARDS   = 36;
   localparam int NUM_PAIRS   = 18;
   localparam int SHOW_CYCLES = 25_000_000;

   typedef logic [5:0] card_addr_t;
   typedef logic [4:0] card_val_t;

   typedef enum logic [2:0] {
      PICK1 = 3'd0,
      READ1 = 3'd1,
      PICK2 = 3'd2,
      READ2 = 3'd3,
      CMP   = 3'd4,
      SHOW  = 3'd5,
      DONE  = 3'd6
   } state_t;
endpackage

// File: rtl/card_match_ctrl_btn_edge.sv
// Registered rising-edge detector for the debounced select button.
module btn_edge (
   input  logic clock,
   input  logic reset,
   input  logic a,
   output logic press
);
   logic a_prev;

   // Reset to 1 so a button already held during reset is not seen as a press.
   always_ff @(posedge clock) begin
      if (reset) a_prev <= 1'b1;
      else       a_prev <= a;
   end

   assign press = a & ~a_prev;
endmodule

// File: rtl/card_match_ctrl.sv
// Turn/compare controller for a 6x6 memory-matching game; card memory is external.
// Optional build macro MOVE_COUNTER_EN adds a saturating 8-bit 'moves' output.
module card_match_ctrl
   import card_pkg::state_t;
   import card_pkg::card_val_t;
   import card_pkg::PICK1;
   import card_pkg::READ1;
   import card_pkg::PICK2;
   import card_pkg::READ2;
   import card_pkg::CMP;
   import card_pkg::SHOW;
   import card_pkg::DONE;
#(
   parameter int NUM_CARDS   = card_pkg::NUM_CARDS,
   parameter int NUM_PAIRS   = card_pkg::NUM_PAIRS,
   parameter int SHOW_CYCLES = card_pkg::SHOW_CYCLES
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 A,
   input  logic [5:0]           cursor,
   output logic [5:0]           rAddr,
   input  logic [4:0]           rData,
   output logic [5:0]           card1Addr,
   output logic [5:0]           card2Addr,
   output logic                 card1Up,
   output logic                 card2Up,
   output logic [NUM_CARDS-1:0] matched,
   output logic [4:0]           pairs,
   output logic                 busy,
   output logic                 GO
`ifdef MOVE_COUNTER_EN
   ,
   output logic [7:0]           moves
`endif
);
   localparam logic [5:0]  LAST_SLOT   = 6'(NUM_CARDS - 1);
   localparam logic [4:0]  PAIRS_TOTAL = 5'(NUM_PAIRS);
   localparam logic [24:0] SHOW_LOAD   = 25'(SHOW_CYCLES - 1);

   state_t      state;
   card_val_t   value1;
   card_val_t   value2;
   logic [24:0] timer;
   logic        press;
   logic        slot_free;
   logic        pick_ok;

   btn_edge u_btn (
      .clock (clock),
      .reset (reset),
      .a     (A),
      .press (press)
   );

   // The range check short-circuits the matched lookup for off-board cursors.
   assign slot_free = (cursor <= LAST_SLOT) && !matched[cursor];
   assign pick_ok   = press && slot_free &&
                      ((state == PICK1) || ((state == PICK2) && (cursor != card1Addr)));

   always_comb begin
      rAddr = cursor;
      if (state == READ1)      rAddr = card1Addr;
      else if (state == READ2) rAddr = card2Addr;
   end

   assign busy = !((state == PICK1) || (state == PICK2) || (state == DONE));
   assign GO   = (state == DONE);

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= PICK1;
         card1Addr <= '0;
         card2Addr <= '0;
         card1Up   <= 1'b0;
         card2Up   <= 1'b0;
         matched   <= '0;
         pairs     <= '0;
         value1    <= '0;
         value2    <= '0;
         timer     <= '0;
      end else begin
         case (state)
            PICK1: if (pick_ok) begin
               card1Addr <= cursor;
               card1Up   <= 1'b1;
               state     <= READ1;
            end
            READ1: begin
               value1 <= rData;
               state  <= PICK2;
            end
            PICK2: if (pick_ok) begin
               card2Addr <= cursor;
               card2Up   <= 1'b1;
               state     <= READ2;
            end
            READ2: begin
               value2 <= rData;
               state  <= CMP;
            end
            CMP: if (value1 == value2) begin
               matched[card1Addr] <= 1'b1;
               matched[card2Addr] <= 1'b1;
               card1Up            <= 1'b0;
               card2Up            <= 1'b0;
               if (pairs != PAIRS_TOTAL) pairs <= pairs + 5'd1;
               state <= ((pairs + 5'd1) >= PAIRS_TOTAL) ? DONE : PICK1;
            end else begin
               timer <= SHOW_LOAD;
               state <= SHOW;
            end
            // Timer counts SHOW_LOAD..0, giving exactly SHOW_CYCLES cycles here.
            SHOW: if (timer == '0) begin
               card1Up <= 1'b0;
               card2Up <= 1'b0;
               state   <= PICK1;
            end else begin
               timer <= timer - 25'd1;
            end
            DONE:    state <= DONE;
            default: state <= PICK1;
         endcase
      end
   end

`ifdef MOVE_COUNTER_EN
   // A move is counted on each entry into CMP, i.e. while leaving READ2.
   always_ff @(posedge clock) begin
      if (reset)                                 moves <= '0;
      else if ((state == READ2) && (moves != 8'hFF)) moves <= moves + 8'd1;
   end
`endif
endmodule

// File: tb/tb_card_match_ctrl.sv
// Directed bench for card_match_ctrl with a behavioural card memory (SHOW_CYCLES=4).
module tb_card_match_ctrl;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        A = 1'b0;
   logic [5:0]  cursor = '0;
   logic [5:0]  rAddr;
   logic [4:0]  rData = '0;
   logic [5:0]  card1Addr, card2Addr;
   logic        card1Up, card2Up;
   logic [35:0] matched;
   logic [4:0]  pairs;
   logic        busy, GO;
`ifdef MOVE_COUNTER_EN
   logic [7:0]  moves;
`endif

   int tests = 0;
   int fails = 0;

   logic [4:0] mem [36];
   int         pa [18];
   int         pb [18];

   card_match_ctrl #(.NUM_CARDS(36), .NUM_PAIRS(18), .SHOW_CYCLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .A         (A),
      .cursor    (cursor),
      .rAddr     (rAddr),
      .rData     (rData),
      .card1Addr (card1Addr),
      .card2Addr (card2Addr),
      .card1Up   (card1Up),
      .card2Up   (card2Up),
      .matched   (matched),
      .pairs     (pairs),
      .busy      (busy),
      .GO        (GO)
`ifdef MOVE_COUNTER_EN
      ,
      .moves     (moves)
`endif
   );

   always #5 clock = ~clock;

   always @(posedge clock) rData <= (rAddr < 6'd36) ? mem[rAddr] : 5'd0;

   typedef struct {
      logic        rst;
      logic        a;
      logic [5:0]  cur;
      logic        up1;
      logic        up2;
      logic        bsy;
      logic        go;
      logic [4:0]  prs;
      logic [5:0]  ra;
      logic [35:0] mt;
   } vec_t;

   vec_t vt [25];

   function automatic vec_t mk(logic r, logic a, logic [5:0] c, logic u1, logic u2,
                               logic b, logic g, logic [4:0] p, logic [5:0] ra,
                               logic [35:0] m);
      vec_t v;
      v.rst = r; v.a = a; v.cur = c; v.up1 = u1; v.up2 = u2;
      v.bsy = b; v.go = g; v.prs = p; v.ra = ra; v.mt = m;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic a, input logic [5:0] c);
      @(negedge clock);
      reset = r; A = a; cursor = c;
      @(posedge clock);
      #1;
   endtask

   logic [35:0] m1, m2, m3;

   initial begin
      // Board: (0,2)=1, (1,4)=2, (3,10)=7, remaining slots paired in order with 8..22
      begin
         int k, prev, val;
         pa[0] = 0; pb[0] = 2; pa[1] = 1; pb[1] = 4; pa[2] = 3; pb[2] = 10;
         mem[0] = 5'd1; mem[2] = 5'd1; mem[1] = 5'd2; mem[4] = 5'd2;
         mem[3] = 5'd7; mem[10] = 5'd7;
         k = 3; prev = -1; val = 8;
         for (int s = 5; s < 36; s++) begin
            if (s != 10) begin
               if (prev < 0) prev = s;
               else begin
                  pa[k] = prev; pb[k] = s;
                  mem[prev] = 5'(val); mem[s] = 5'(val);
                  k++; val++; prev = -1;
               end
            end
         end
      end

      m1 = (36'd1 << 3) | (36'd1 << 10);
      m2 = m1 | (36'd1 << 5) | (36'd1 << 6);
      m3 = m2 | (36'd1 << 7) | (36'd1 << 8);

      //         rst a  cur  up1 up2 bsy go prs  raddr mt
      vt[0]  = mk(1, 0, 0,   0,  0,  0,  0, 0,   0,   '0);
      vt[1]  = mk(0, 0, 0,   0,  0,  0,  0, 0,   0,   '0);
      vt[2]  = mk(0, 1, 3,   1,  0,  1,  0, 0,   3,   '0);
      vt[3]  = mk(0, 0, 3,   1,  0,  0,  0, 0,   3,   '0);
      vt[4]  = mk(0, 1, 10,  1,  1,  1,  0, 0,   10,  '0);
      vt[5]  = mk(0, 0, 10,  1,  1,  1,  0, 0,   10,  '0);
      vt[6]  = mk(0, 0, 10,  0,  0,  0,  0, 1,   10,  m1);
      vt[7]  = mk(0, 1, 5,   1,  0,  1,  0, 1,   5,   m1);
      vt[8]  = mk(0, 0, 5,   1,  0,  0,  0, 1,   5,   m1);
      vt[9]  = mk(0, 1, 5,   1,  0,  0,  0, 1,   5,   m1);
      vt[10] = mk(0, 0, 3,   1,  0,  0,  0, 1,   3,   m1);
      vt[11] = mk(0, 1, 3,   1,  0,  0,  0, 1,   3,   m1);
      vt[12] = mk(0, 0, 40,  1,  0,  0,  0, 1,   40,  m1);
      vt[13] = mk(0, 1, 40,  1,  0,  0,  0, 1,   40,  m1);
      vt[14] = mk(0, 0, 6,   1,  0,  0,  0, 1,   6,   m1);
      vt[15] = mk(0, 1, 6,   1,  1,  1,  0, 1,   6,   m1);
      vt[16] = mk(0, 0, 6,   1,  1,  1,  0, 1,   6,   m1);
      vt[17] = mk(0, 0, 6,   0,  0,  0,  0, 2,   6,   m2);
      vt[18] = mk(0, 1, 7,   1,  0,  1,  0, 2,   7,   m2);
      vt[19] = mk(0, 1, 8,   1,  0,  0,  0, 2,   8,   m2);
      vt[20] = mk(0, 1, 8,   1,  0,  0,  0, 2,   8,   m2);
      vt[21] = mk(0, 0, 8,   1,  0,  0,  0, 2,   8,   m2);
      vt[22] = mk(0, 1, 8,   1,  1,  1,  0, 2,   8,   m2);
      vt[23] = mk(0, 0, 8,   1,  1,  1,  0, 2,   8,   m2);
      vt[24] = mk(0, 0, 8,   0,  0,  0,  0, 3,   8,   m3);

      for (int i = 0; i < 25; i++) begin
         step(vt[i].rst, vt[i].a, vt[i].cur);
         chk($sformatf("vec%0d", i),
             64'({card1Up, card2Up, busy, GO, pairs, rAddr, matched}),
             64'({vt[i].up1, vt[i].up2, vt[i].bsy, vt[i].go, vt[i].prs, vt[i].ra, vt[i].mt}));
      end

      // Mismatch 0/1: four SHOW cycles, with a press ignored during SHOW
      step(0, 1, 0); step(0, 0, 0); step(0, 1, 1); step(0, 0, 1);
      chk("cmp_busy", 64'({busy, card1Up, card2Up}), 64'(3'b111));
      for (int i = 0; i < 4; i++) begin
         step(0, (i == 1), (i == 1) ? 6'd2 : 6'd1);
         chk($sformatf("show%0d", i), 64'({busy, card1Up, card2Up}), 64'(3'b111));
      end
      step(0, 0, 1);
      chk("show_exit", 64'({busy, card1Up, card2Up, pairs, matched}), 64'({3'b000, 5'd3, m3}));
      step(0, 1, 2);
      chk("pick1_after_show", 64'({busy, card1Up, card1Addr}), 64'({2'b11, 6'd2}));

      // Reset asserted mid-SHOW clears everything on the next edge
      step(0, 0, 2); step(0, 1, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
      chk("in_show", 64'({busy, card1Up, card2Up}), 64'(3'b111));
      step(1, 0, 0);
      chk("reset_mid_show",
          64'({card1Addr, card2Addr, card1Up, card2Up, matched, pairs, busy, GO, rAddr}), 64'(0));

      // A held high across reset release must not register a press
      step(1, 1, 3);
      step(0, 1, 3);
      chk("held_a_release", 64'({busy, card1Up}), 64'(2'b00));
      step(0, 1, 3);
      chk("held_a_still", 64'({busy, card1Up}), 64'(2'b00));
      step(0, 0, 3);

      // Clear all 18 pairs
      for (int k = 0; k < 18; k++) begin
         step(0, 1, 6'(pa[k])); step(0, 0, 6'(pa[k]));
         step(0, 1, 6'(pb[k])); step(0, 0, 6'(pb[k]));
         chk($sformatf("cmp_go%0d", k), 64'({GO, busy}), 64'(2'b01));
         step(0, 0, 6'(pb[k]));
         chk($sformatf("pair%0d", k), 64'({GO, pairs}), 64'({(k == 17), 5'(k + 1)}));
      end
      chk("all_matched", 64'(matched), 64'(36'hF_FFFF_FFFF));
      step(0, 1, 5); step(0, 0, 5); step(0, 1, 6);
      chk("done_absorbing", 64'({GO, busy, card1Up, card2Up, pairs}), 64'({4'b1000, 5'd18}));
      step(1, 0, 0);
      chk("done_reset", 64'({GO, matched, pairs}), 64'(0));

`ifdef MOVE_COUNTER_EN
      step(0, 0, 0);
      chk("moves_reset", 64'(moves), 64'(0));
      for (int n = 0; n < 300; n++) begin
         step(0, 1, 0); step(0, 0, 0); step(0, 1, 1); step(0, 0, 1);
         for (int j = 0; j < 5; j++) step(0, 0, 1);
         if (n == 0) chk("moves_first", 64'(moves), 64'(1));
      end
      chk("moves_sat", 64'(moves), 64'(255));
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
